// File: rtl/secded_dec_seq_if.sv
// Memory-port bundle between the SECDED decode sequencer and the shared
// single-port data memory.
//   mem_req   : requester wants the port this cycle
//   mem_gnt   : arbiter grant; an access issues only when req && gnt
//   mem_addr  : byte address
//   mem_re    : read strobe (read data returns on the following cycle)
//   mem_we    : write strobe
//   mem_wdata : write byte
//   mem_rdata : read byte
// master modport: the sequencer. slave modport: the memory/arbiter side.
interface secded_dec_seq_if #(
  parameter int AW = 8
) ();
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_re, mem_we, mem_wdata,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/secded_dec_seq.sv
// SECDED Hamming decode sequencer. On start it reads MSG_COUNT 16-bit
// codewords (two bytes each, low byte first) from SRC_BASE, decodes each,
// and writes {flags[1:0], 3'b000, d11..d1} back as two bytes at DST_BASE.
// flags: 00 clean, 01 single error (corrected), 10 double error.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high
//   start    : one-cycle pulse, accepted only in IDLE or DONE
//   done     : high in DONE until the next accepted start or reset
//   mem      : master side of the secded_dec_seq_if memory bundle
//   n_single : count of single-error codewords (SECDED_DEC_STATS_EN only)
//   n_double : count of double-error codewords (SECDED_DEC_STATS_EN only)
// Optional feature macro: SECDED_DEC_STATS_EN (adds the saturating counters).
module secded_dec_seq #(
  parameter int MSG_COUNT = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int AW        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  secded_dec_seq_if.master mem
`ifdef SECDED_DEC_STATS_EN
  ,
  output logic [7:0]       n_single,
  output logic [7:0]       n_double
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_WAIT_HI, S_DEC, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic          r_rd_pend;   // a read issued last cycle; rdata is valid now
  logic          r_rd_hi;     // that read was the high byte
  logic          w_start_acc;
  logic [7:0]    r_lo, r_hi;
  logic [15:0]   w_res_p0, r_res_p1;
  logic [AW-1:0] w_src, w_dst;

  // Syndrome is the XOR of the indices of set bits; P==1 means an odd number
  // of flips, so bit s is corrected (s==0 points at p0, data untouched).
  function automatic logic [15:0] f_decode(input logic [15:0] cw);
    logic [3:0]  s;
    logic        p;
    logic [15:0] c;
    logic [1:0]  fl;
    s  = 4'd0;
    for (int k = 1; k < 16; k++)
      if (cw[k]) s = s ^ 4'(k);
    p  = ^cw;
    c  = cw;
    fl = 2'b00;
    if (p) begin
      fl = 2'b01;
      if (s != 4'd0) c[s] = ~c[s];
    end else if (s != 4'd0) begin
      fl = 2'b10;
    end
    return {fl, 3'b000, c[15:9], c[7:5], c[3]};
  endfunction

  function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_src    = AW'(SRC_BASE) + (r_idx << 1);
  assign w_dst    = AW'(DST_BASE) + (r_idx << 1);
  assign w_res_p0 = f_decode({r_hi, r_lo});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_hi   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_idx     <= w_idx_nxt;
      r_rd_pend <= mem.mem_re;
      r_rd_hi   <= (r_state == S_RD_HI);
    end
  end

  // Stage p0 -> p1: byte capture and registered decode result
  always_ff @(posedge clk) begin
    if (r_rd_pend) begin
      if (r_rd_hi) r_hi <= mem.mem_rdata;
      else         r_lo <= mem.mem_rdata;
    end
    if (r_state == S_DEC) r_res_p1 <= w_res_p0;
  end

  always_comb begin
    w_next        = r_state;
    w_idx_nxt     = r_idx;
    w_start_acc   = 1'b0;
    done          = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_re    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = 8'h00;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_start_acc = 1'b1;
          w_idx_nxt   = '0;
          w_next      = (MSG_COUNT == 0) ? S_DONE : S_RD_LO;
        end
      end
      S_RD_LO: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = w_src;
        mem.mem_re   = mem.mem_gnt;
        if (mem.mem_gnt) w_next = S_RD_HI;
      end
      S_RD_HI: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = w_src + AW'(1);
        mem.mem_re   = mem.mem_gnt;
        if (mem.mem_gnt) w_next = S_WAIT_HI;
      end
      S_WAIT_HI: w_next = S_DEC;
      S_DEC:     w_next = S_WR_LO;
      S_WR_LO: begin
        mem.mem_req   = 1'b1;
        mem.mem_addr  = w_dst;
        mem.mem_wdata = r_res_p1[7:0];
        mem.mem_we    = mem.mem_gnt;
        if (mem.mem_gnt) w_next = S_WR_HI;
      end
      S_WR_HI: begin
        mem.mem_req   = 1'b1;
        mem.mem_addr  = w_dst + AW'(1);
        mem.mem_wdata = r_res_p1[15:8];
        mem.mem_we    = mem.mem_gnt;
        if (mem.mem_gnt) begin
          if (r_idx == AW'(MSG_COUNT - 1)) begin
            w_next = S_DONE;
          end else begin
            w_next    = S_RD_LO;
            w_idx_nxt = r_idx + AW'(1);
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef SECDED_DEC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_single <= 8'd0;
      n_double <= 8'd0;
    end else if (w_start_acc) begin
      n_single <= 8'd0;
      n_double <= 8'd0;
    end else if (r_state == S_DEC) begin
      if (w_res_p0[15:14] == 2'b01) n_single <= f_sat_inc(n_single);
      if (w_res_p0[15:14] == 2'b10) n_double <= f_sat_inc(n_double);
    end
  end
`endif

endmodule
